// File: rtl/dpram_arbiter.sv
// dpram_arbiter: round-robin sharing of a dual-port RAM's single write port
// and single read port between two requesters, with one-cycle read response,
// same-cycle write-to-read bypass and an optional post-reset zero scrub.
// Optional feature macro: DPRAM_ARB_SCRUB_EN (adds the SCRUB state, its
// address counter and o_busy; without it RUN starts straight out of reset).
module dpram_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr0_valid,
  output logic                  o_wr0_ready,
  input  logic [ADDR_WIDTH-1:0] i_wr0_addr,
  input  logic [XLEN-1:0]       i_wr0_data,
  input  logic                  i_wr1_valid,
  output logic                  o_wr1_ready,
  input  logic [ADDR_WIDTH-1:0] i_wr1_addr,
  input  logic [XLEN-1:0]       i_wr1_data,
  input  logic                  i_rd0_valid,
  output logic                  o_rd0_ready,
  input  logic [ADDR_WIDTH-1:0] i_rd0_addr,
  output logic                  o_rd0_rvalid,
  output logic [XLEN-1:0]       o_rd0_rdata,
  input  logic                  i_rd1_valid,
  output logic                  o_rd1_ready,
  input  logic [ADDR_WIDTH-1:0] i_rd1_addr,
  output logic                  o_rd1_rvalid,
  output logic [XLEN-1:0]       o_rd1_rdata,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_wAddr,
  output logic [XLEN-1:0]       o_ram_dataIn,
  output logic [ADDR_WIDTH-1:0] o_ram_rAddr,
  input  logic [XLEN-1:0]       i_ram_q,
  output logic                  o_busy
);

  // Arbitration enables and scrub write source
  logic                  run;
  logic                  scrub_we;
  logic [ADDR_WIDTH-1:0] scrub_addr;

  // Grants and round-robin pointers (pointer value = requester holding priority)
  logic wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic bypass_hit;

  // Read response tag, bypass capture and held read data
  logic            tag_vld_q, tag_req_q;
  logic            byp_q;
  logic [XLEN-1:0] byp_data_q;
  logic [XLEN-1:0] rdata0_q, rdata1_q;
  logic [XLEN-1:0] resp_data;

  // Round-robin grants per port and next priority pointers
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave a signal unassigned and infer a latch.
    wr_gnt0  = run && i_wr0_valid && (!i_wr1_valid || !wr_ptr_q);
    wr_gnt1  = run && i_wr1_valid && (!i_wr0_valid ||  wr_ptr_q);
    rd_gnt0  = run && i_rd0_valid && (!i_rd1_valid || !rd_ptr_q);
    rd_gnt1  = run && i_rd1_valid && (!i_rd0_valid ||  rd_ptr_q);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_gnt0)      wr_ptr_d = 1'b1;
    else if (wr_gnt1) wr_ptr_d = 1'b0;
    if (rd_gnt0)      rd_ptr_d = 1'b1;
    else if (rd_gnt1) rd_ptr_d = 1'b0;
  end

  assign o_wr0_ready = wr_gnt0;
  assign o_wr1_ready = wr_gnt1;
  assign o_rd0_ready = rd_gnt0;
  assign o_rd1_ready = rd_gnt1;

  // RAM write/read port muxing: scrub, then the winning requester, else zero
  always_comb begin
    o_ram_we     = 1'b0;
    o_ram_wAddr  = '0;
    o_ram_dataIn = '0;
    o_ram_rAddr  = '0;
    if (scrub_we) begin
      o_ram_we    = 1'b1;
      o_ram_wAddr = scrub_addr;
    end else if (wr_gnt0) begin
      o_ram_we     = 1'b1;
      o_ram_wAddr  = i_wr0_addr;
      o_ram_dataIn = i_wr0_data;
    end else if (wr_gnt1) begin
      o_ram_we     = 1'b1;
      o_ram_wAddr  = i_wr1_addr;
      o_ram_dataIn = i_wr1_data;
    end
    if (rd_gnt0)      o_ram_rAddr = i_rd0_addr;
    else if (rd_gnt1) o_ram_rAddr = i_rd1_addr;
  end

  // The RAM returns pre-write data on a same-address collision, so a
  // colliding read is answered from the captured write data instead.
  assign bypass_hit = (rd_gnt0 || rd_gnt1) && (wr_gnt0 || wr_gnt1) &&
                      (o_ram_rAddr == o_ram_wAddr);

  // Priority pointers, read tag, bypass capture and held read data
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      tag_vld_q  <= 1'b0;
      tag_req_q  <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_vld_q  <= rd_gnt0 || rd_gnt1;
      tag_req_q  <= rd_gnt1;
      byp_q      <= bypass_hit;
      byp_data_q <= o_ram_dataIn;
      rdata0_q   <= o_rd0_rdata;
      rdata1_q   <= o_rd1_rdata;
    end
  end

  // Response goes to the tagged requester only; the other holds its data
  assign resp_data    = byp_q ? byp_data_q : i_ram_q;
  assign o_rd0_rvalid = !i_rst && tag_vld_q && !tag_req_q;
  assign o_rd1_rvalid = !i_rst && tag_vld_q &&  tag_req_q;
  assign o_rd0_rdata  = i_rst ? '0 : (o_rd0_rvalid ? resp_data : rdata0_q);
  assign o_rd1_rdata  = i_rst ? '0 : (o_rd1_rvalid ? resp_data : rdata1_q);

`ifdef DPRAM_ARB_SCRUB_EN
  typedef enum logic {ST_SCRUB, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] scrub_cnt_q, scrub_cnt_d;

  // State and scrub address counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_SCRUB;
      scrub_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      scrub_cnt_q <= scrub_cnt_d;
    end
  end

  // Step the counter through every address; leave SCRUB after the top one
  always_comb begin
    state_d     = state_q;
    scrub_cnt_d = scrub_cnt_q;
    if (state_q == ST_SCRUB) begin
      if (&scrub_cnt_q) state_d     = ST_RUN;
      else              scrub_cnt_d = scrub_cnt_q + ADDR_WIDTH'(1);
    end
  end

  assign run        = !i_rst && (state_q == ST_RUN);
  assign scrub_we   = !i_rst && (state_q == ST_SCRUB);
  assign scrub_addr = scrub_cnt_q;
  assign o_busy     = i_rst || (state_q == ST_SCRUB);
`else
  assign run        = !i_rst;
  assign scrub_we   = 1'b0;
  assign scrub_addr = '0;
  assign o_busy     = 1'b0;
`endif

endmodule
